// File: rtl/neural_unit_sequencer.sv
`default_nettype none
// =============================================================================
// neural_unit_sequencer : per-layer weight load / trigger / capture controller
// Rev 1.0 - initial release
// =============================================================================
module neural_unit_sequencer #(
   parameter int NUM_LAYERS    = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_LAYERS-1:0] act_mask,
   input  logic                  w_valid,
   input  logic [7:0]            w_data,
   output logic                  w_ready,
   output logic [7:0]            nu_weight,
   output logic [1:0]            nu_address,
   output logic                  nu_write,
   output logic                  nu_sum_trigger,
   output logic                  nu_layer_sel,
   output logic                  nu_activate,
   input  logic [31:0]           nu_layer_out,
   input  logic                  nu_layer_done,
   output logic                  result_valid,
   output logic [31:0]           result_data,
   output logic [3:0]            result_layer,
   output logic                  busy,
   output logic                  error
);

   localparam logic [3:0]  LAST_LAYER   = 4'(NUM_LAYERS - 1);
   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_TRIG   = 3'd3,
      S_WAIT   = 3'd4,
      S_NEXT   = 3'd5
   } state_t;

   state_t                state_q,  state_d;
   logic [NUM_LAYERS-1:0] mask_q,   mask_d;
   logic [3:0]            layer_q,  layer_d;
   logic [1:0]            widx_q,   widx_d;
   logic [15:0]           timer_q,  timer_d;
   logic [7:0]            weight_q, weight_d;
   logic [1:0]            addr_q,   addr_d;
   logic                  write_q,  write_d;
   logic                  rvalid_q, rvalid_d;
   logic [31:0]           rdata_q,  rdata_d;
   logic [3:0]            rlayer_q, rlayer_d;
   logic                  error_q,  error_d;
   logic [NUM_LAYERS-1:0] mask_shift;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         layer_q  <= '0;
         widx_q   <= '0;
         timer_q  <= '0;
         weight_q <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rlayer_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         layer_q  <= layer_d;
         widx_q   <= widx_d;
         timer_q  <= timer_d;
         weight_q <= weight_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rlayer_q <= rlayer_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      layer_d  = layer_q;
      widx_d   = widx_q;
      timer_d  = timer_q;
      weight_d = weight_q;
      addr_d   = addr_q;
      write_d  = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rlayer_d = rlayer_q;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               mask_d  = act_mask;
               layer_d = '0;
               widx_d  = '0;
               error_d = 1'b0;
            end
         end
         S_LOAD: begin
            // The write strobe for the fourth weight lands in the first SETTLE cycle.
            if (w_valid) begin
               weight_d = w_data;
               addr_d   = widx_q;
               write_d  = 1'b1;
               widx_d   = widx_q + 2'd1;
               if (widx_q == 2'd3) begin
                  state_d = S_SETTLE;
                  timer_d = '0;
               end
            end
         end
         S_SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
               state_d = S_TRIG;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_TRIG: begin
            state_d = S_WAIT;
            timer_d = '0;
         end
         S_WAIT: begin
            // Done wins over a timeout landing in the same cycle.
            if (nu_layer_done) begin
               rdata_d  = nu_layer_out;
               rlayer_d = layer_q;
               rvalid_d = 1'b1;
               state_d  = S_NEXT;
            end else if (timer_q == TIMEOUT_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else if (timer_q != 16'hFFFF) begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_NEXT: begin
            if (layer_q == LAST_LAYER) begin
               state_d = S_IDLE;
            end else begin
               layer_d = layer_q + 4'd1;
               widx_d  = '0;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mask_shift     = mask_q >> layer_q;
   assign busy           = (state_q != S_IDLE);
   assign w_ready        = (state_q == S_LOAD);
   assign nu_sum_trigger = (state_q == S_TRIG);
   assign nu_activate    = (state_q == S_WAIT);
   assign nu_layer_sel   = busy & mask_shift[0];
   assign nu_weight      = weight_q;
   assign nu_address     = addr_q;
   assign nu_write       = write_q;
   assign result_valid   = rvalid_q;
   assign result_data    = rdata_q;
   assign result_layer   = rlayer_q;
   assign error          = error_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_unit_sequencer.sv
`default_nettype none
// =============================================================================
// tb_neural_unit_sequencer : scoreboard bench with randomized layer runs
// Rev 1.0 - initial release
// =============================================================================
module tb_neural_unit_sequencer;
   localparam int NL = 2;
   localparam int SC = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [NL-1:0] act_mask;
   logic          w_valid;
   logic [7:0]    w_data;
   logic          w_ready;
   logic [7:0]    nu_weight;
   logic [1:0]    nu_address;
   logic          nu_write;
   logic          nu_sum_trigger;
   logic          nu_layer_sel;
   logic          nu_activate;
   logic [31:0]   nu_layer_out;
   logic          nu_layer_done;
   logic          result_valid;
   logic [31:0]   result_data;
   logic [3:0]    result_layer;
   logic          busy;
   logic          error;

   always #5 clk = ~clk;

   neural_unit_sequencer #(.NUM_LAYERS(NL), .SETTLE_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .act_mask(act_mask),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .nu_weight(nu_weight), .nu_address(nu_address), .nu_write(nu_write),
      .nu_sum_trigger(nu_sum_trigger), .nu_layer_sel(nu_layer_sel), .nu_activate(nu_activate),
      .nu_layer_out(nu_layer_out), .nu_layer_done(nu_layer_done),
      .result_valid(result_valid), .result_data(result_data), .result_layer(result_layer),
      .busy(busy), .error(error)
   );

   typedef struct packed { logic [1:0] addr; logic [7:0] data; } wr_t;
   typedef struct packed { logic [3:0] layer; logic [31:0] data; } res_t;

   wr_t  exp_wr_q[$];
   res_t exp_res_q[$];
   bit   exp_sel_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_wr_cyc = 0;
   bit cur_sel = 1'b0;
   wr_t  mw;
   res_t mr;
   bit   ms;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every DUT-presented event is checked against the scoreboard queues.
   always @(negedge clk) begin
      if (nu_write) begin
         if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            mw = exp_wr_q.pop_front();
            check("wr_addr", nu_address, mw.addr);
            check("wr_data", nu_weight, mw.data);
         end
         last_wr_cyc = cyc;
      end
      if (nu_sum_trigger) begin
         check("trig_gap_after_last_write", cyc - last_wr_cyc, SC);
         if (exp_sel_q.size() == 0) begin
            check("unexpected_trigger", 1, 0);
         end else begin
            ms = exp_sel_q.pop_front();
            check("trig_layer_sel", nu_layer_sel, ms);
            cur_sel = ms;
         end
      end
      if (nu_activate && (nu_layer_sel != cur_sel))
         check("wait_layer_sel", nu_layer_sel, cur_sel);
      if (result_valid) begin
         if (exp_res_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            mr = exp_res_q.pop_front();
            check("result_layer", result_layer, mr.layer);
            check("result_data", result_data, mr.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_weight(input int gap, input int idx);
      wr_t e;
      if (gap > 0) begin
         w_valid = 1'b0;
         repeat (gap) begin
            w_data = 8'($urandom);
            tick();
         end
      end
      e.addr  = 2'(idx);
      e.data  = 8'($urandom);
      w_valid = 1'b1;
      w_data  = e.data;
      exp_wr_q.push_back(e);
      for (int k = 0; k < 50 && !w_ready; k++) tick();
      if (!w_ready) begin
         check("w_ready_timeout", 0, 1);
         w_valid = 1'b0;
         return;
      end
      tick();
   endtask

   // Reference: layer L uses act_mask[L]; a done within TO wait cycles yields (L, value),
   // otherwise the run ends with error set and no result.
   task automatic run_seq(input logic [NL-1:0] mask, input int d0, input int d1,
                          input bit spurious, input int gapmode);
      int          dly[NL];
      int          gaps[4];
      bit          seen;
      logic [31:0] val;
      res_t        r;
      dly[0] = d0;
      dly[1] = d1;
      act_mask = mask;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      act_mask = ~mask;
      check("busy_after_start", busy, 1);
      check("error_cleared_by_start", error, 0);
      if (spurious) begin
         nu_layer_done = 1'b1;
         nu_layer_out  = $urandom;
         tick();
         nu_layer_done = 1'b0;
      end
      for (int L = 0; L < NL; L++) begin
         exp_sel_q.push_back(mask[L]);
         for (int i = 0; i < 4; i++) begin
            if (gapmode == 1)      gaps[i] = 0;
            else if (gapmode == 2) gaps[i] = (i == 1) ? 2 : ((i == 3) ? 1 : 0);
            else                   gaps[i] = $urandom_range(0, 2);
         end
         for (int i = 0; i < 4; i++) send_weight(gaps[i], i);
         w_valid = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            if (nu_sum_trigger) seen = 1'b1;
            else tick();
         end
         check("trigger_seen", seen, 1);
         if (!seen) return;
         if (dly[L] <= TO) begin
            val     = $urandom;
            r.layer = 4'(L);
            r.data  = val;
            exp_res_q.push_back(r);
            for (int k = 0; k < dly[L]; k++) begin
               tick();
               start = (spurious && k == 0 && dly[L] > 1);
            end
            start         = 1'b0;
            nu_layer_done = 1'b1;
            nu_layer_out  = val;
            tick();
            nu_layer_done = 1'b0;
            nu_layer_out  = $urandom;
            check("busy_in_next", busy, 1);
            if (L == NL - 1) begin
               tick();
               check("idle_after_last_next", busy, 0);
               check("no_error_on_done", error, 0);
            end
         end else begin
            repeat (TO) tick();
            check("no_error_before_timeout", error, 0);
            check("busy_before_timeout", busy, 1);
            tick();
            check("error_on_timeout", error, 1);
            check("idle_after_timeout", busy, 0);
            return;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_nu_write"}, nu_write, 0);
      check({tag, "_w_ready"}, w_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_nu_weight_addr"}, {nu_weight, nu_address}, 0);
      check({tag, "_trig_act_sel"}, {nu_sum_trigger, nu_activate, nu_layer_sel}, 0);
      check({tag, "_result"}, {result_valid, result_layer, result_data}, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; act_mask = '0; w_valid = 1'b0; w_data = '0;
      nu_layer_out = '0; nu_layer_done = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      tick();

      run_seq(2'b00, 3, 3, 1'b0, 1);
      tick();
      run_seq(2'b10, 3, 5, 1'b0, 1);
      tick();
      run_seq(2'b01, 2, TO, 1'b0, 2);
      tick();
      run_seq(2'b11, TO + 1, 1, 1'b0, 0);
      tick();
      run_seq(2'b10, 4, 3, 1'b1, 0);
      tick();

      // Asynchronous reset in the middle of LOAD, after two weights.
      act_mask = 2'b01;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_weight(0, 0);
      send_weight(0, 1);
      #1 reset = 1'b1;
      #1;
      check_all_zero("midload_reset");
      exp_wr_q.delete();
      w_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      run_seq(2'b01, 3, 2, 1'b0, 1);
      tick();

      for (int n = 0; n < 8; n++) begin
         run_seq(2'($urandom), $urandom_range(1, TO + 2), $urandom_range(1, TO + 2),
                 1'($urandom), 0);
         repeat ($urandom_range(1, 3)) tick();
      end

      repeat (4) tick();
      check("writes_outstanding", exp_wr_q.size(), 0);
      check("results_outstanding", exp_res_q.size(), 0);
      check("triggers_outstanding", exp_sel_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
